// File: rtl/soldier_pkg.sv
// Shared encodings and defaults for the foot-soldier controller.
package soldier_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_MOVE = 3'd1,
        S_STOP = 3'd2,
        S_ATK  = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    localparam int DEF_W        = 10;
    localparam int DEF_STEP     = 1;
    localparam int DEF_MOVE_DIV = 1;
    localparam int DEF_WAIT_CYC = 8;
    localparam int DEF_ATK_CYC  = 8;
    localparam int DEF_HP_W     = 4;
    localparam int DEF_HP_MAX   = 10;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soldier_unit_phase_counter.sv
// Shared phase counter: flags count == max-1, then wraps to zero.
module phase_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] max,
    output logic          flag
);

    logic [CW-1:0] count;

    assign flag = (count == max - 1'b1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= flag ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/soldier_unit.sv
// Foot-soldier controller: walk, wait/attack cadence, damage and death.
module soldier_unit
    import soldier_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int STEP     = DEF_STEP,
    parameter int MOVE_DIV = DEF_MOVE_DIV,
    parameter int WAIT_CYC = DEF_WAIT_CYC,
    parameter int ATK_CYC  = DEF_ATK_CYC,
    parameter int HP_W     = DEF_HP_W,
    parameter int HP_MAX   = DEF_HP_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               dir,
    input  logic [W-1:0]       left_bound,
    input  logic [W-1:0]       right_bound,
    input  logic               block,
    input  logic               hit,
    input  logic [HP_W-1:0]    dmg,
    output logic [W-1:0]       pos_h,
    output logic [STATE_W-1:0] state_o,
    output logic [HP_W-1:0]    hp,
    output logic               atk_strobe,
    output logic               alive
);

    localparam int CMAX = max3(MOVE_DIV, WAIT_CYC, ATK_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state, nxt;
    logic [W-1:0]  nxt_pos, spawn;
    logic [W:0]    ahead, back_lim;
    logic [HP_W-1:0] nhp;
    logic          active, lethal, flag;
    logic          cnt_en, cnt_clr, sync_rst;
    logic [CW-1:0] cnt_max;

    assign sync_rst = rst || !valid;
    assign state_o  = state;
    assign alive    = (state != S_DEAD);

    always_comb begin
        spawn    = dir ? left_bound : right_bound;
        ahead    = {1'b0, pos_h} + (W+1)'(STEP);
        back_lim = {1'b0, left_bound} + (W+1)'(STEP);
        active   = (state == S_MOVE) || (state == S_STOP) || (state == S_ATK);
        nhp      = (hp > dmg) ? hp - dmg : '0;
        lethal   = hit && active && (nhp == '0);
        nxt      = state;
        nxt_pos  = pos_h;
        cnt_en   = 1'b0;
        cnt_max  = CW'(1);
        case (state)
            S_IDLE: begin
                nxt     = S_MOVE;
                nxt_pos = spawn;
            end
            S_MOVE: begin
                cnt_en  = !block;
                cnt_max = CW'(MOVE_DIV);
                if (!block && flag) begin
                    if (dir) begin
                        if (ahead < {1'b0, right_bound}) begin
                            nxt_pos = ahead[W-1:0];
                        end else begin
                            nxt_pos = right_bound;
                            nxt     = S_STOP;
                        end
                    end else begin
                        if ({1'b0, pos_h} > back_lim) begin
                            nxt_pos = pos_h - W'(STEP);
                        end else begin
                            nxt_pos = left_bound;
                            nxt     = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                cnt_en  = 1'b1;
                cnt_max = CW'(WAIT_CYC);
                if (flag) nxt = S_ATK;
            end
            S_ATK: begin
                cnt_en  = 1'b1;
                cnt_max = CW'(ATK_CYC);
                if (flag) nxt = S_STOP;
            end
            default: ;
        endcase
        // A lethal hit wins over any step or phase change this cycle
        if (lethal) begin
            nxt     = S_DEAD;
            nxt_pos = pos_h;
        end
        cnt_clr = (nxt != state);
    end

    phase_counter #(.CW(CW)) u_phase (
        .clk  (clk),
        .rst  (sync_rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .max  (cnt_max),
        .flag (flag)
    );

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state      <= S_IDLE;
            pos_h      <= spawn;
            hp         <= HP_W'(HP_MAX);
            atk_strobe <= 1'b0;
        end else begin
            state      <= nxt;
            pos_h      <= nxt_pos;
            atk_strobe <= (state == S_STOP) && (nxt == S_ATK);
            if (hit && active) hp <= nhp;
        end
    end

endmodule

// File: doc/soldier_unit.md
# soldier_unit

Parametrised next-generation foot-soldier controller. Walks a unit horizontally from its spawn bound toward the opposite bound at a configurable speed and step, then alternates between waiting and attacking. Adds a hold-back input for collision with a friendly unit ahead, damage intake with hit points, and a DEAD state. One instance per unit; its position feeds the sprite renderer and its attack strobe feeds the damage arbiter.

## Interface
- `W`, 10: position width in pixels.
- `STEP`, 1: pixels moved per move tick; must be ≥1 and less than `right_bound - left_bound`.
- `MOVE_DIV`, 1: clocks per move tick; must be ≥1.
- `WAIT_CYC`, 8: cycles spent in STOP before each attack; must be ≥1.
- `ATK_CYC`, 8: cycles spent in ATK; must be ≥1.
- `HP_W`, 4: hit-point width.
- `HP_MAX`, 10: hit points at spawn; must be ≥1 and less than 2^HP_W.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `valid`, input, 1: unit exists. Low acts exactly like `rst`.
- `dir`, input, 1: 1 = spawn at left and walk right; 0 = spawn at right and walk left.
- `left_bound`, input, W: left limit; left < right is required.
- `right_bound`, input, W: right limit.
- `block`, input, 1: friendly unit directly ahead; freezes movement.
- `hit`, input, 1: damage event this cycle.
- `dmg`, input, HP_W: damage amount, sampled when `hit` = 1.
- `pos_h`, output, W: registered horizontal position.
- `state_o`, output, 3: registered state code.
- `hp`, output, HP_W: registered hit points.
- `atk_strobe`, output, 1: one-cycle pulse on the first cycle of each ATK.
- `alive`, output, 1: combinational; high when `state_o` ≠ DEAD.

## Operation
- States: IDLE=0, MOVE=1, STOP=2, ATK=3, DEAD=4.
- `rst` or `!valid`:
  - state ← IDLE; `pos_h` ← (`dir` ? `left_bound` : `right_bound`).
  - `hp` ← `HP_MAX`; phase counter ← 0; `atk_strobe` ← 0.
- IDLE → MOVE unconditionally. `pos_h` is reloaded with the spawn bound.
- MOVE:
  - With `block` = 1: `pos_h` and the phase counter hold.
  - With `block` = 0: the counter increments. On count = `MOVE_DIV`-1 the counter wraps to 0 and a step occurs.
  - Step, `dir` = 1: if `pos_h` + STEP < `right_bound`, then `pos_h` += STEP. Otherwise `pos_h` ← `right_bound` and go to STOP.
  - Step, `dir` = 0: if `pos_h` > `left_bound` + STEP, then `pos_h` −= STEP. Otherwise `pos_h` ← `left_bound` and go to STOP.
  - All comparisons are evaluated in W+1 bits, so there is no wrap-around.
- STOP: `pos_h` holds; the counter increments; on count = `WAIT_CYC`-1, go to ATK.
- ATK: `pos_h` holds; the counter increments; on count = `ATK_CYC`-1, go to STOP. `atk_strobe` is high only in the first ATK cycle. `block` is ignored in STOP and ATK.
- The phase counter clears to 0 on every state change.
- Damage applies in MOVE, STOP and ATK:
  - `hp` ← `hp` − `dmg`, saturating at 0.
  - If the result is 0, go to DEAD. This overrides any other transition in the same cycle, and no `atk_strobe` is issued.
  - `hit` is ignored in IDLE and DEAD. `dmg` = 0 leaves `hp` unchanged.
- DEAD: `pos_h` and `hp` hold. Leaves only via `rst` / `!valid`.
- `dir` and the bounds are sampled every cycle. Changing them mid-walk is legal and takes effect on the next step.

## Timing
- All outputs are registered except `alive`. Reset values: state IDLE, `pos_h` = spawn bound, `hp` = `HP_MAX`, `atk_strobe` 0, `alive` 1.
- The first MOVE cycle follows one cycle after reset is released.
- With `MOVE_DIV` = 1, the first step is visible on the cycle after entering MOVE.
- STOP lasts exactly `WAIT_CYC` cycles and ATK exactly `ATK_CYC` cycles, so attacks repeat every `WAIT_CYC` + `ATK_CYC` cycles.
- A `hit` is reflected in `hp` (and in DEAD, if lethal) on the next edge.
- Reset asserted mid-operation takes effect on the next edge and overrides hit and step in that cycle.

## Structure
- `soldier_pkg`: state encoding constants, state width (3), and the default parameter values.
- Sub-module `phase_counter`, parametrised by width:
  - inputs `clr`, `en`, `max`; output `flag` (count = `max`-1).
  - Wraps to 0 after `flag`.
  - Shared by the MOVE, STOP and ATK phases; sized to the largest of `MOVE_DIV`, `WAIT_CYC`, `ATK_CYC`.

## Test plan
- Walk right. Defaults, `dir`=1, left=100, right=105 → `pos_h` 100 (IDLE), 100, 101, 102, 103, 104, then 105 with STOP.
- Walk left with stepping. `dir`=0, left=20, right=30, STEP=4, MOVE_DIV=2 → `pos_h` 30, steps to 26 and then 22 every 2 cycles, then clamps to 20 with STOP; never underflows.
- Attack cadence. After reaching STOP → 8 STOP cycles, `atk_strobe` one pulse, 8 ATK cycles, repeating every 16 cycles.
- Block. `block`=1 for 5 cycles mid-walk → `pos_h` frozen for 5 cycles; the walk resumes with the counter phase preserved.
- Damage and death:
  - hit `dmg`=3 three times → `hp` 7, 4, 1.
  - hit `dmg`=5 → `hp` 0, DEAD, `alive`=0, `pos_h` frozen.
  - a further hit → no change.
  - `valid`=0 → IDLE, `hp`=10.
- Lethal hit in the STOP→ATK cycle → DEAD, no `atk_strobe`. `rst` asserted during ATK → IDLE with the spawn bound on the next edge.
